// File: rtl/tama_pkg.sv
// Shared definitions for the tamagotchi ASCII byte interface.
// STATS_REPORTER_CHECKSUM_EN lengthens the status frame to carry a hex XOR checksum.
package tama_pkg;

    // ASCII characters used in the status line
    localparam logic [7:0] ASC_H  = 8'h48;
    localparam logic [7:0] ASC_P  = 8'h50;
    localparam logic [7:0] ASC_D  = 8'h44;
    localparam logic [7:0] ASC_B  = 8'h42;
    localparam logic [7:0] ASC_E  = 8'h45;
    localparam logic [7:0] ASC_A  = 8'h41;
    localparam logic [7:0] ASC_Z  = 8'h5A;
    localparam logic [7:0] ASC_SP = 8'h20;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_0  = 8'h30;

`ifdef STATS_REPORTER_CHECKSUM_EN
    localparam int FRAME_LEN = 26;
`else
    localparam int FRAME_LEN = 23;
`endif

    typedef logic [4:0] stat_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } rep_state_t;

    // One nibble as an uppercase hex ASCII character
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) return ASC_0 + {4'h0, n};
        else           return 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/stats_reporter_bin2dec5.sv
// Combinational conversion of a 0..31 value into two zero-padded ASCII decimal digits.
module bin2dec5
    import tama_pkg::*;
(
    input  logic [4:0] value,
    output logic [7:0] tens,
    output logic [7:0] ones
);

    logic [1:0] tens_d;
    logic [4:0] base;
    logic [4:0] rem_d;

    // Pick the tens digit by range, then subtract its weight for the ones digit
    always_comb begin
        tens_d = 2'd0;
        base   = 5'd0;
        if (value >= 5'd30) begin
            tens_d = 2'd3;
            base   = 5'd30;
        end else if (value >= 5'd20) begin
            tens_d = 2'd2;
            base   = 5'd20;
        end else if (value >= 5'd10) begin
            tens_d = 2'd1;
            base   = 5'd10;
        end
        rem_d = value - base;
        tens  = ASC_0 + {6'd0, tens_d};
        ones  = ASC_0 + {3'd0, rem_d};
    end

endmodule

// File: rtl/stats_reporter.sv
// Status line generator: snapshots the pet stats and streams an ASCII report
// "Hdd Pdd Ddd Bdd Edd S\r\n" to the UART transmitter.
// Build option STATS_REPORTER_CHECKSUM_EN adds " XX" (XOR of bytes 0..20 in hex) before CR.
//
// Handshake: tx_data/tx_valid are held stable while tx_valid is high and tx_ready is low;
// a byte moves only in a cycle where both tx_valid and tx_ready are high. tx_ready is
// ignored while tx_valid is low.
module stats_reporter
    import tama_pkg::*;
#(
    parameter int         REPORT_EVERY = 2,
    parameter logic [7:0] SLEEP_CHAR   = 8'h5A
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       second,
    input  logic       req,
    input  logic [4:0] hunger,
    input  logic [4:0] happiness,
    input  logic [4:0] health,
    input  logic [4:0] hygiene,
    input  logic [4:0] energy,
    input  logic       is_sleeping,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy
);

    localparam logic [15:0] REPORT_LIM = 16'(REPORT_EVERY);
    localparam logic [4:0]  LAST_IDX   = 5'(FRAME_LEN - 1);

    rep_state_t  state, state_next;
    logic        second_q;
    logic [15:0] tick_cnt;
    logic [4:0]  idx;
    logic        pending;
    stat_t       snap_hunger, snap_happiness, snap_health, snap_hygiene, snap_energy;
    logic        snap_sleep;

    logic        tick, auto_trig, trigger, start, xfer;
    logic [7:0]  frame_byte, sleep_byte;
    logic [7:0]  hu_t, hu_o, ha_t, ha_o, he_t, he_o, hy_t, hy_o, en_t, en_o;

    assign tick      = (second != second_q);
    assign auto_trig = (REPORT_LIM != 16'd0) && tick && (tick_cnt == REPORT_LIM - 16'd1);
    assign trigger   = auto_trig || req;

    // Edge detector on the animation toggle and the periodic tick counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            second_q <= 1'b0;
            tick_cnt <= 16'd0;
        end else begin
            second_q <= second;
            if (REPORT_LIM != 16'd0 && tick) begin
                if (tick_cnt == REPORT_LIM - 16'd1) tick_cnt <= 16'd0;
                else                                tick_cnt <= tick_cnt + 16'd1;
            end
        end
    end

    // Report state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state, handshake outputs and datapath strobes
    always_comb begin
        state_next = state;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        busy       = 1'b0;
        start      = 1'b0;
        xfer       = 1'b0;
        case (state)
            IDLE: begin
                if (trigger || pending) begin
                    start      = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = frame_byte;
                busy     = 1'b1;
                if (tx_ready) begin
                    xfer = 1'b1;
                    if (idx == LAST_IDX) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Snapshot capture, byte index and the one-deep pending request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx            <= 5'd0;
            pending        <= 1'b0;
            snap_hunger    <= '0;
            snap_happiness <= '0;
            snap_health    <= '0;
            snap_hygiene   <= '0;
            snap_energy    <= '0;
            snap_sleep     <= 1'b0;
        end else begin
            if (start) begin
                idx            <= 5'd0;
                snap_hunger    <= hunger;
                snap_happiness <= happiness;
                snap_health    <= health;
                snap_hygiene   <= hygiene;
                snap_energy    <= energy;
                snap_sleep     <= is_sleeping;
            end else if (xfer) begin
                idx <= (idx == LAST_IDX) ? 5'd0 : idx + 5'd1;
            end
            // A trigger that starts a report also consumes any pending one
            if (start)                         pending <= 1'b0;
            else if (state == SEND && trigger) pending <= 1'b1;
        end
    end

    bin2dec5 u_dec_hunger    (.value(snap_hunger),    .tens(hu_t), .ones(hu_o));
    bin2dec5 u_dec_happiness (.value(snap_happiness), .tens(ha_t), .ones(ha_o));
    bin2dec5 u_dec_health    (.value(snap_health),    .tens(he_t), .ones(he_o));
    bin2dec5 u_dec_hygiene   (.value(snap_hygiene),   .tens(hy_t), .ones(hy_o));
    bin2dec5 u_dec_energy    (.value(snap_energy),    .tens(en_t), .ones(en_o));

    assign sleep_byte = snap_sleep ? SLEEP_CHAR : ASC_A;

`ifdef STATS_REPORTER_CHECKSUM_EN
    logic [7:0] csum;

    // XOR of every byte from 'H' through the state character
    always_comb begin
        csum = ASC_H ^ hu_t ^ hu_o ^ ASC_SP
             ^ ASC_P ^ ha_t ^ ha_o ^ ASC_SP
             ^ ASC_D ^ he_t ^ he_o ^ ASC_SP
             ^ ASC_B ^ hy_t ^ hy_o ^ ASC_SP
             ^ ASC_E ^ en_t ^ en_o ^ ASC_SP
             ^ sleep_byte;
    end
`endif

    // Frame byte selected by the current index
    always_comb begin
        frame_byte = 8'h00;
        case (idx)
            5'd0:  frame_byte = ASC_H;
            5'd1:  frame_byte = hu_t;
            5'd2:  frame_byte = hu_o;
            5'd3:  frame_byte = ASC_SP;
            5'd4:  frame_byte = ASC_P;
            5'd5:  frame_byte = ha_t;
            5'd6:  frame_byte = ha_o;
            5'd7:  frame_byte = ASC_SP;
            5'd8:  frame_byte = ASC_D;
            5'd9:  frame_byte = he_t;
            5'd10: frame_byte = he_o;
            5'd11: frame_byte = ASC_SP;
            5'd12: frame_byte = ASC_B;
            5'd13: frame_byte = hy_t;
            5'd14: frame_byte = hy_o;
            5'd15: frame_byte = ASC_SP;
            5'd16: frame_byte = ASC_E;
            5'd17: frame_byte = en_t;
            5'd18: frame_byte = en_o;
            5'd19: frame_byte = ASC_SP;
            5'd20: frame_byte = sleep_byte;
`ifdef STATS_REPORTER_CHECKSUM_EN
            5'd21: frame_byte = ASC_SP;
            5'd22: frame_byte = hex_char(csum[7:4]);
            5'd23: frame_byte = hex_char(csum[3:0]);
            5'd24: frame_byte = ASC_CR;
            5'd25: frame_byte = ASC_LF;
`else
            5'd21: frame_byte = ASC_CR;
            5'd22: frame_byte = ASC_LF;
`endif
            default: frame_byte = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_stats_reporter.sv
// Self-checking bench for stats_reporter: a byte scoreboard fed from a frame model.
module tb_stats_reporter;

`ifdef STATS_REPORTER_CHECKSUM_EN
    localparam int FLEN = 26;
`else
    localparam int FLEN = 23;
`endif
    localparam int BOUND = 2000;

    logic       clk = 1'b0;
    logic       reset;
    logic       second;
    logic       req;
    logic [4:0] hunger, happiness, health, hygiene, energy;
    logic       is_sleeping;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;

    logic [7:0] exp_q[$];

    int n_vec = 0;
    int n_miss = 0;
    int mon_pos = 0;
    int frames_done = 0;
    int n_xfer = 0;
    int cyc = 0;
    int lf_cyc = 0;
    int last_gap = 0;
    bit prev_valid = 0;
    bit have_hold = 0;
    bit check_after_lf = 0;
    logic [7:0] hold_data = 8'h00;

    stats_reporter #(.REPORT_EVERY(2), .SLEEP_CHAR(8'h5A)) dut (
        .clk(clk), .reset(reset), .second(second), .req(req),
        .hunger(hunger), .happiness(happiness), .health(health),
        .hygiene(hygiene), .energy(energy), .is_sleeping(is_sleeping),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dec_tens(input logic [4:0] v);
        int iv = int'(v);
        return 8'h30 + 8'(iv / 10);
    endfunction

    function automatic logic [7:0] dec_ones(input logic [4:0] v);
        int iv = int'(v);
        return 8'h30 + 8'(iv % 10);
    endfunction

    function automatic logic [7:0] hex_model(input logic [3:0] n);
        int iv = int'(n);
        return (iv < 10) ? 8'(48 + iv) : 8'(55 + iv);
    endfunction

    // Model of one status line, pushed to the scoreboard
    task automatic push_frame(input logic [4:0] h, input logic [4:0] p, input logic [4:0] d,
                              input logic [4:0] b, input logic [4:0] e, input logic s);
        logic [7:0] fr[26];
        logic [7:0] x;
        fr[0]  = "H"; fr[1]  = dec_tens(h); fr[2]  = dec_ones(h); fr[3]  = " ";
        fr[4]  = "P"; fr[5]  = dec_tens(p); fr[6]  = dec_ones(p); fr[7]  = " ";
        fr[8]  = "D"; fr[9]  = dec_tens(d); fr[10] = dec_ones(d); fr[11] = " ";
        fr[12] = "B"; fr[13] = dec_tens(b); fr[14] = dec_ones(b); fr[15] = " ";
        fr[16] = "E"; fr[17] = dec_tens(e); fr[18] = dec_ones(e); fr[19] = " ";
        fr[20] = s ? 8'h5A : 8'h41;
        x = 8'h00;
        for (int i = 0; i <= 20; i++) x = x ^ fr[i];
`ifdef STATS_REPORTER_CHECKSUM_EN
        fr[21] = " "; fr[22] = hex_model(x[7:4]); fr[23] = hex_model(x[3:0]);
        fr[24] = 8'h0D; fr[25] = 8'h0A;
`else
        fr[21] = 8'h0D; fr[22] = 8'h0A;
        fr[23] = 8'h00; fr[24] = 8'h00; fr[25] = 8'h00;
`endif
        for (int i = 0; i < FLEN; i++) exp_q.push_back(fr[i]);
    endtask

    // Output monitor: predicts the transfer at the coming rising edge
    always @(negedge clk) begin
        logic [7:0] e;
        if (reset) begin
            mon_pos = 0;
            have_hold = 0;
            check_after_lf = 0;
            prev_valid = 0;
        end else begin
            if (check_after_lf) begin
                check("busy_after_lf", 32'(busy), 32'd0);
                check("valid_after_lf", 32'(tx_valid), 32'd0);
                check_after_lf = 0;
            end
            if (have_hold) begin
                check("hold_valid", 32'(tx_valid), 32'd1);
                check("hold_data", 32'(tx_data), 32'(hold_data));
            end
            have_hold = 0;
            if (tx_valid && !prev_valid) last_gap = cyc - lf_cyc;
            prev_valid = tx_valid;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_byte", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", 32'(tx_data), 32'(e));
                end
                mon_pos++;
                n_xfer++;
                if (mon_pos == FLEN) begin
                    mon_pos = 0;
                    frames_done++;
                    lf_cyc = cyc;
                    check_after_lf = 1;
                end
            end else if (tx_valid) begin
                have_hold = 1;
                hold_data = tx_data;
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req();
        req = 1'b1;
        step();
        req = 1'b0;
    endtask

    task automatic set_stats(input logic [4:0] h, input logic [4:0] p, input logic [4:0] d,
                             input logic [4:0] b, input logic [4:0] e, input logic s);
        hunger = h; happiness = p; health = d; hygiene = b; energy = e; is_sleeping = s;
    endtask

    task automatic wait_idle(input bit rand_ready);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < BOUND) begin
            if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        tx_ready = 1'b1;
        check("idle_queue_empty", 32'(exp_q.size()), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic wait_pos(input int pos);
        int n = 0;
        while (mon_pos != pos && n < BOUND) begin
            step();
            n++;
        end
        check("reach_byte_pos", 32'(mon_pos), 32'(pos));
    endtask

    initial begin
        int base_f;
        int base_x;
        reset = 1'b1; second = 1'b0; req = 1'b0; tx_ready = 1'b0;
        set_stats(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (3) step();
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        step();

        // Snapshot and format, full-rate sink
        tx_ready = 1'b1;
        set_stats(5'd7, 5'd3, 5'd15, 5'd0, 5'd31, 1'b1);
        base_f = frames_done;
        push_frame(5'd7, 5'd3, 5'd15, 5'd0, 5'd31, 1'b1);
        check("valid_before_req", 32'(tx_valid), 32'd0);
        pulse_req();
        check("valid_latency", 32'(tx_valid), 32'd1);
        check("busy_on_start", 32'(busy), 32'd1);
        check("first_byte_h", 32'(tx_data), 32'h48);
        wait_idle(1'b0);
        check("frames_basic", 32'(frames_done - base_f), 32'd1);

        // Backpressure with random ready
        set_stats(5'd19, 5'd28, 5'd9, 5'd10, 5'd1, 1'b0);
        base_x = n_xfer;
        push_frame(5'd19, 5'd28, 5'd9, 5'd10, 5'd1, 1'b0);
        tx_ready = 1'b0;
        pulse_req();
        wait_idle(1'b1);
        check("bp_transfers", 32'(n_xfer - base_x), 32'(FLEN));

        // All-zero awake frame (checksum frame in the checksum build)
        set_stats(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        push_frame(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        pulse_req();
        wait_idle(1'b0);

        // Random stats frames under random backpressure
        for (int k = 0; k < 3; k++) begin
            logic [4:0] rv[5];
            logic rs;
            for (int j = 0; j < 5; j++) rv[j] = 5'($urandom_range(0, 31));
            rs = 1'($urandom_range(0, 1));
            set_stats(rv[0], rv[1], rv[2], rv[3], rv[4], rs);
            push_frame(rv[0], rv[1], rv[2], rv[3], rv[4], rs);
            pulse_req();
            set_stats(5'd31, 5'd31, 5'd31, 5'd31, 5'd31, ~rs);
            wait_idle(1'b1);
        end

        // Periodic reports: four second toggles give two reports, snapshot held mid-frame
        base_f = frames_done;
        set_stats(5'd1, 5'd2, 5'd3, 5'd4, 5'd10, 1'b0);
        second = 1'b1;
        repeat (4) step();
        check("no_report_first_tick", 32'(busy), 32'd0);
        push_frame(5'd1, 5'd2, 5'd3, 5'd4, 5'd10, 1'b0);
        second = 1'b0;
        repeat (4) step();
        energy = 5'd11;
        wait_idle(1'b0);
        second = 1'b1;
        repeat (4) step();
        check("no_report_third_tick", 32'(busy), 32'd0);
        push_frame(5'd1, 5'd2, 5'd3, 5'd4, 5'd11, 1'b0);
        second = 1'b0;
        step();
        wait_idle(1'b0);
        check("periodic_frames", 32'(frames_done - base_f), 32'd2);

        // Pending: three requests during a frame give exactly one more frame
        base_f = frames_done;
        last_gap = 0;
        set_stats(5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 1'b1);
        push_frame(5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 1'b1);
        pulse_req();
        wait_pos(5);
        set_stats(5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 1'b0);
        push_frame(5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 1'b0);
        pulse_req();
        step();
        pulse_req();
        step();
        pulse_req();
        wait_idle(1'b0);
        check("pending_frames", 32'(frames_done - base_f), 32'd2);
        check("pending_gap", 32'(last_gap), 32'd2);
        repeat (30) step();
        check("pending_no_extra", 32'(frames_done - base_f), 32'd2);
        check("pending_idle_busy", 32'(busy), 32'd0);

        // Reset mid-frame, then a fresh frame from 'H'
        set_stats(5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 1'b0);
        push_frame(5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 1'b0);
        pulse_req();
        wait_pos(9);
        reset = 1'b1;
        #1;
        check("midrst_valid", 32'(tx_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_data", 32'(tx_data), 32'd0);
        exp_q.delete();
        step();
        reset = 1'b0;
        step();
        set_stats(5'd30, 5'd29, 5'd0, 5'd9, 5'd10, 1'b1);
        push_frame(5'd30, 5'd29, 5'd0, 5'd9, 5'd10, 1'b1);
        pulse_req();
        check("post_rst_first_byte", 32'(tx_data), 32'h48);
        wait_idle(1'b0);

        repeat (5) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
